// File: rtl/banco_registros_pkg.sv
// Shared constants and types for the banco_registros register file.
package banco_registros_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 4;
  localparam int REG_DEPTH  = 2 ** REG_ADDR_W;

  typedef logic [REG_DATA_W-1:0] reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Whole register file as one packed vector of words, handy to pass between modules.
  typedef logic [REG_DEPTH-1:0][REG_DATA_W-1:0] reg_bank_t;

endpackage

// File: rtl/banco_registros_if.sv
// Bus bundle for the register file: two read ports (A, B) and two write ports (C, V).
interface banco_registros_if;
  import banco_registros_pkg::*;

  logic      WE_C;
  logic      WE_V;
  reg_addr_t DirA;
  reg_addr_t DirB;
  reg_addr_t DirC;
  reg_addr_t DirV;
  reg_word_t DinC;
  reg_word_t DinV;
  reg_word_t DoA;
  reg_word_t DoB;

  // Datapath side: drives addresses, enables and write data, consumes read data.
  modport master (
    output WE_C, WE_V, DirA, DirB, DirC, DirV, DinC, DinV,
    input  DoA, DoB
  );

  // Register file side.
  modport slave (
    input  WE_C, WE_V, DirA, DirB, DirC, DirV, DinC, DinV,
    output DoA, DoB
  );

endinterface

// File: rtl/banco_registros_read_mux.sv
// 16:1 word-wide combinational read multiplexer for one read port.
module banco_read_mux
  import banco_registros_pkg::*;
(
  input  reg_bank_t i_regs,
  input  reg_addr_t i_sel,
  output reg_word_t o_data
);

  // Pure selection; zero-cycle latency from address to data.
  assign o_data = i_regs[i_sel];

endmodule

// File: rtl/banco_registros.sv
// Register file, 16 x 32 bits: asynchronous reads on A/B, synchronous writes on C/V.
// On a same-address dual write, port C wins. No read bypass: a read of the
// register being written shows the old value until the clock edge.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  banco_registros_if.slave    bus
);

  reg_bank_t r_regs;
  reg_word_t w_doa;
  reg_word_t w_dob;

  // Storage: async clear; port V assigned first so a colliding port C write overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '0;
    end else begin
      if (bus.WE_V) r_regs[bus.DirV] <= bus.DinV;
      if (bus.WE_C) r_regs[bus.DirC] <= bus.DinC;
    end
  end

  banco_read_mux u_mux_a (
    .i_regs (r_regs),
    .i_sel  (bus.DirA),
    .o_data (w_doa)
  );

  banco_read_mux u_mux_b (
    .i_regs (r_regs),
    .i_sel  (bus.DirB),
    .o_data (w_dob)
  );

  assign bus.DoA = w_doa;
  assign bus.DoB = w_dob;

endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: directed scenarios plus randomized traffic against
// an array-based reference model of the 16 registers.
module tb_banco_registros;
  import banco_registros_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  banco_registros_if bus ();

  banco_registros dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_ports();
    bus.WE_C = 1'b0; bus.WE_V = 1'b0;
    bus.DirC = '0;   bus.DirV = '0;
    bus.DinC = '0;   bus.DinV = '0;
  endtask

  // One clock edge; the model applies the writes presented before the edge.
  task automatic tick();
    logic        wc, wv;
    logic [3:0]  ac, av;
    logic [31:0] dc, dv;
    wc = bus.WE_C; wv = bus.WE_V; ac = bus.DirC; av = bus.DirV;
    dc = bus.DinC; dv = bus.DinV;
    @(posedge clk);
    if (!rst) begin
      if (wv) model[av] = dv;
      if (wc) model[ac] = dc;   // C overrides V on collision
    end
    #1;
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
    bus.DirA = a; bus.DirB = b;
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      read_ab(4'(i), 4'(15 - i));
      chk($sformatf("%s_A%0d", tag, i), bus.DoA, model[i]);
      chk($sformatf("%s_B%0d", tag, 15 - i), bus.DoB, model[15 - i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    idle_ports();
    bus.DirA = '0; bus.DirB = '0;

    // Reset state
    #2;
    check_all("reset_init");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill some registers, then assert reset mid-cycle
    for (int i = 0; i < 16; i++) begin
      bus.WE_C = 1'b1; bus.DirC = 4'(i); bus.DinC = 32'h1000 + i;
      tick();
    end
    idle_ports();
    check_all("prefill");
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1;
    read_ab(4'd3, 4'd12);
    chk("rst_async_A3", bus.DoA, 32'h0);
    chk("rst_async_B12", bus.DoB, 32'h0);
    check_all("rst_mid");
    // Writes ignored while reset held
    @(negedge clk);
    bus.WE_C = 1'b1; bus.DirC = 4'd6; bus.DinC = 32'hDEAD_BEEF;
    bus.WE_V = 1'b1; bus.DirV = 4'd2; bus.DinV = 32'h1234_5678;
    tick();
    read_ab(4'd6, 4'd2);
    chk("rst_we_ignored_A", bus.DoA, 32'h0);
    chk("rst_we_ignored_B", bus.DoB, 32'h0);
    idle_ports();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Port V write only
    bus.WE_V = 1'b1; bus.DirV = 4'd15; bus.DinV = 32'd19;
    bus.WE_C = 1'b0; bus.DirC = 4'd3;  bus.DinC = 32'd54;
    tick();
    read_ab(4'd15, 4'd3);
    chk("portV_R15", bus.DoA, 32'd19);
    read_ab(4'd3, 4'd15);
    chk("portV_R3_untouched", bus.DoA, 32'd0);

    // Port C write only
    @(negedge clk);
    bus.WE_C = 1'b1; bus.DirC = 4'd3;  bus.DinC = 32'd54;
    bus.WE_V = 1'b0; bus.DirV = 4'd15; bus.DinV = 32'd99;
    tick();
    read_ab(4'd3, 4'd15);
    chk("portC_R3", bus.DoA, 32'd54);
    chk("portC_R15_keep", bus.DoB, 32'd19);

    // Dual write, different addresses
    @(negedge clk);
    bus.WE_C = 1'b1; bus.DirC = 4'd5; bus.DinC = 32'hA5A5_A5A5;
    bus.WE_V = 1'b1; bus.DirV = 4'd9; bus.DinV = 32'hFFFF_FFFF;
    tick();
    idle_ports();
    read_ab(4'd5, 4'd9);
    chk("dual_R5", bus.DoA, 32'hA5A5_A5A5);
    chk("dual_R9", bus.DoB, 32'hFFFF_FFFF);

    // Collision: C wins
    @(negedge clk);
    bus.WE_C = 1'b1; bus.DirC = 4'd7; bus.DinC = 32'd1;
    bus.WE_V = 1'b1; bus.DirV = 4'd7; bus.DinV = 32'd2;
    tick();
    idle_ports();
    read_ab(4'd7, 4'd7);
    chk("collide_R7_A", bus.DoA, 32'd1);
    chk("collide_R7_B", bus.DoB, 32'd1);

    // Read-during-write: no bypass
    @(negedge clk);
    read_ab(4'd4, 4'd4);
    bus.WE_C = 1'b1; bus.DirC = 4'd4; bus.DinC = 32'd8;
    #1;
    chk("rdw_before", bus.DoA, 32'd0);
    tick();
    chk("rdw_after", bus.DoA, 32'd8);
    idle_ports();

    // Write-then-read sweep of all addresses, on both ports
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.WE_V = 1'b1; bus.DirV = 4'(i); bus.DinV = $urandom;
      tick();
      idle_ports();
      read_ab(4'(i), 4'(i));
      chk($sformatf("sweep_A%0d", i), bus.DoA, model[i]);
      chk($sformatf("sweep_B%0d", i), bus.DoB, model[i]);
    end
    check_all("sweep_all");

    // Randomized traffic, including forced collisions
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.WE_C = 1'($urandom); bus.WE_V = 1'($urandom);
      bus.DirC = 4'($urandom); bus.DirV = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.DirV = bus.DirC;
      bus.DinC = $urandom;     bus.DinV = $urandom;
      read_ab(4'($urandom), 4'($urandom));
      chk("rnd_pre_A", bus.DoA, model[bus.DirA]);
      chk("rnd_pre_B", bus.DoB, model[bus.DirB]);
      tick();
      chk("rnd_post_A", bus.DoA, model[bus.DirA]);
      chk("rnd_post_B", bus.DoB, model[bus.DirB]);
    end
    idle_ports();
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
